tl45_mdu_seq: RTL and testbench

TL45_MDU_SEQ -- requirements
Module: tl45_mdu_seq

---
 rtl/tl45_pkg.sv | 17 +
 rtl/tl45_mdu_iter.sv | 68 ++++++
 rtl/tl45_mdu_seq.sv | 116 +++++++++++
 tb/tb_tl45_mdu_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl45_pkg.sv
// Shared TL45 definitions: MDU operation encodings and the MDU sequencer state set.
package tl45_pkg;

    typedef enum logic [1:0] {
        MDU_MUL  = 2'd0,
        MDU_DIVU = 2'd1,
        MDU_REMU = 2'd2,
        MDU_RSVD = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/tl45_mdu_iter.sv
// One-bit-per-cycle MDU datapath: shift-add multiply and restoring divide
// sharing a single accumulator and two shift registers.
module tl45_mdu_iter
    import tl45_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_step,
    input  mdu_op_t          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    // acc: product / partial remainder; x: multiplicand / dividend-quotient; y: multiplier / divisor
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // When the trial subtraction fits, the true difference is below the divisor,
    // so the low WIDTH bits of the wrapped difference are exact.
    assign shifted = {acc, x[WIDTH-1]};
    assign fits    = shifted >= {1'b0, y};
    assign diff    = shifted[WIDTH-1:0] - y;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc <= '0;
            x   <= '0;
            y   <= '0;
        end else if (i_load) begin
            acc <= '0;
            x   <= i_a;
            y   <= i_b;
        end else if (i_step) begin
            if (i_op == MDU_MUL) begin
                if (y[0])
                    acc <= acc + x;
                x <= {x[WIDTH-2:0], 1'b0};
                y <= {1'b0, y[WIDTH-1:1]};
            end else if (fits) begin
                acc <= diff;
                x   <= {x[WIDTH-2:0], 1'b1};
            end else begin
                acc <= shifted[WIDTH-1:0];
                x   <= {x[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        o_result = '0;
        case (i_op)
            MDU_MUL:  o_result = acc;
            MDU_DIVU: o_result = x;
            MDU_REMU: o_result = acc;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/tl45_mdu_seq.sv
// TL45 multiply/divide sequencer: accepts one op from the ALU stage, iterates
// WIDTH cycles in tl45_mdu_iter and presents a registered result until taken.
module tl45_mdu_seq
    import tl45_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_dr,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [3:0]       o_dr,
    output logic [WIDTH-1:0] o_value
);

    mdu_state_t       state;
    mdu_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    mdu_op_t          op_q;
    logic [3:0]       dr_q;
    logic             valid_q;
    logic [3:0]       dr_out_q;
    logic [WIDTH-1:0] value_q;
    logic             accept;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] result;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = (mdu_op_t'(i_op) == MDU_RSVD) ? DONE : RUN;
                RUN:  if (last) state_nxt = DONE;
                DONE: if (valid_q && i_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        o_req_ready = (state == IDLE) && !i_flush;
        accept      = i_req_valid && o_req_ready;
        o_busy      = (state == RUN) || (state == DONE);
        step        = (state == RUN) && !i_flush;
        last        = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    end

    // The result is registered one cycle after entering DONE, which is where the
    // extra cycle of latency beyond the WIDTH iterations comes from.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt      <= '0;
            op_q     <= MDU_MUL;
            dr_q     <= '0;
            valid_q  <= 1'b0;
            dr_out_q <= '0;
            value_q  <= '0;
        end else begin
            cnt <= step ? cnt + CNT_W'(1) : '0;
            if (accept) begin
                op_q <= mdu_op_t'(i_op);
                dr_q <= i_dr;
            end
            if (i_flush) begin
                valid_q  <= 1'b0;
                dr_out_q <= '0;
                value_q  <= '0;
            end else if (state == DONE && !valid_q) begin
                valid_q  <= 1'b1;
                dr_out_q <= dr_q;
                value_q  <= result;
            end else if (valid_q && i_ready) begin
                valid_q  <= 1'b0;
                dr_out_q <= '0;
                value_q  <= '0;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_dr    = dr_out_q;
    assign o_value = value_q;

    tl45_mdu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (accept),
        .i_step   (step),
        .i_op     (op_q),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_result (result)
    );

endmodule

// File: tb/tb_tl45_mdu_seq.sv
// Self-checking bench for tl45_mdu_seq: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_tl45_mdu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          i_reset, i_flush, i_req_valid, i_ready;
    logic [1:0]    i_op;
    logic [W-1:0]  i_a, i_b;
    logic [3:0]    i_dr;
    logic          o_req_ready, o_busy, o_valid;
    logic [3:0]    o_dr;
    logic [W-1:0]  o_value;

    int tests = 0;
    int fails = 0;

    tl45_mdu_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_flush     (i_flush),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_op        (i_op),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_dr        (i_dr),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_dr        (o_dr),
        .o_value     (o_value)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (op)
            2'd0: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return p[W-1:0]; end
            2'd1: return (b == 0) ? {W{1'b1}} : a / b;
            2'd2: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op);
        return (op == 2'd3) ? 1 : W + 1;
    endfunction

    // Stimulus only: issue one op, scramble operands afterwards, wait (bounded) for o_valid.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] dr, input logic rdy,
                         output logic [W-1:0] val, output logic [3:0] rdr, output int lat,
                         output logic acc_rdy);
        i_req_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_dr = dr; i_ready = rdy;
        acc_rdy = o_req_ready;
        tick();
        i_req_valid = 1'b0;
        i_op = 2'($urandom); i_a = $urandom; i_b = $urandom; i_dr = 4'($urandom);
        lat = 0;
        while (!o_valid && lat < 100) begin
            tick();
            lat++;
        end
        val = o_value;
        rdr = o_dr;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_flush = 1'b0; i_req_valid = 1'b0; i_ready = 1'b0;
        i_op = '0; i_a = '0; i_b = '0; i_dr = '0;
        tick(); tick();
        i_reset = 1'b0;
        tests++;
        if ({o_valid, o_busy, o_dr, o_value, o_req_ready} !== {1'b0, 1'b0, 4'd0, {W{1'b0}}, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: valid=%0b busy=%0b dr=%0d value=%h ready=%0b, want 0 0 0 0 1",
                     o_valid, o_busy, o_dr, o_value, o_req_ready);
        end
        i_flush = 1'b1; #1;
        tests++;
        if (o_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_during_flush: got %0b want 0", o_req_ready);
        end
        i_flush = 1'b0;
        i_reset = 1'b1; i_req_valid = 1'b1; i_op = 2'd0; i_a = 5; i_b = 5;
        tick();
        i_reset = 1'b0; i_req_valid = 1'b0;
        tests++;
        if (o_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_beats_request: busy=%0b want 0", o_busy);
        end
    endtask

    task automatic test_mul_basic();
        logic [W-1:0] v; logic [3:0] d; int lat; logic ar;
        do_op(2'd0, 7, 6, 4'd3, 1'b1, v, d, lat, ar);
        tests++;
        if (ar !== 1'b1 || lat !== W + 1 || v !== 42 || d !== 4'd3) begin
            fails++;
            $display("FAIL mul_7x6: ready=%0b lat=%0d value=%0d dr=%0d, want 1 %0d 42 3", ar, lat, v, d, W + 1);
        end
        tick();
        tests++;
        if (o_valid !== 1'b0 || o_value !== '0 || o_dr !== 4'd0) begin
            fails++;
            $display("FAIL mul_pulse: valid=%0b value=%h dr=%0d after handshake, want 0 0 0", o_valid, o_value, o_dr);
        end
        tests++;
        if (o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL mul_back_idle: ready=%0b busy=%0b, want 1 0", o_req_ready, o_busy);
        end
    endtask

    task automatic test_directed();
        logic [1:0]   ops [6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
        logic [W-1:0] as  [6] = '{32'hFFFF_FFFF, 32'd100, 32'd100, 32'h1234, 32'h1234, 32'hDEAD};
        logic [W-1:0] bs  [6] = '{32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hBEEF};
        logic [W-1:0] exp [6] = '{32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'd0};
        logic [W-1:0] v; logic [3:0] d; int lat; logic ar;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], 4'(i + 5), 1'b1, v, d, lat, ar);
            tests++;
            if (v !== exp[i] || d !== 4'(i + 5) || lat !== model_lat(ops[i])) begin
                fails++;
                $display("FAIL directed_%0d op=%0d: value=%h dr=%0d lat=%0d, want %h %0d %0d",
                         i, ops[i], v, d, lat, exp[i], i + 5, model_lat(ops[i]));
            end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] v; logic [3:0] d; int lat; logic ar;
        do_op(2'd1, 32'd1000, 32'd9, 4'd12, 1'b0, v, d, lat, ar);
        tests++;
        if (v !== 32'd111 || d !== 4'd12) begin
            fails++;
            $display("FAIL hold_value: value=%0d dr=%0d, want 111 12", v, d);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (o_valid !== 1'b1 || o_value !== 32'd111 || o_dr !== 4'd12 || o_req_ready !== 1'b0 || o_busy !== 1'b1) begin
                fails++;
                $display("FAIL hold_cycle_%0d: valid=%0b value=%0d dr=%0d ready=%0b busy=%0b, want 1 111 12 0 1",
                         k, o_valid, o_value, o_dr, o_req_ready, o_busy);
            end
        end
        i_ready = 1'b1;
        tick();
        tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_release: valid=%0b busy=%0b ready=%0b, want 0 0 1", o_valid, o_busy, o_req_ready);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] v; logic [3:0] d; int lat; logic ar;
        logic seen = 1'b0;
        i_req_valid = 1'b1; i_op = 2'd0; i_a = 32'd123; i_b = 32'd456; i_dr = 4'd9; i_ready = 1'b1;
        tick();
        i_req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen |= o_valid;
            tick();
        end
        i_flush = 1'b1;
        tick();
        seen |= o_valid;
        tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_value !== '0 || o_dr !== 4'd0) begin
            fails++;
            $display("FAIL flush_idle: busy=%0b valid=%0b value=%h dr=%0d, want 0 0 0 0", o_busy, o_valid, o_value, o_dr);
        end
        i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        i_flush = 1'b0;
        tests++;
        if (o_busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_blocks_request: busy=%0b want 0", o_busy);
        end
        for (int k = 0; k < W + 4; k++) begin
            seen |= o_valid;
            tick();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL flush_no_valid: o_valid seen=%0b want 0", seen);
        end
        do_op(2'd0, 3, 3, 4'd1, 1'b1, v, d, lat, ar);
        tests++;
        if (ar !== 1'b1 || v !== 32'd9 || d !== 4'd1 || lat !== W + 1) begin
            fails++;
            $display("FAIL flush_then_mul: ready=%0b value=%0d dr=%0d lat=%0d, want 1 9 1 %0d", ar, v, d, lat, W + 1);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] v; logic [3:0] d; int lat; logic ar;
        logic seen = 1'b0;
        do_op(2'd2, 32'd77, 32'd10, 4'd4, 1'b0, v, d, lat, ar);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 1'b1 || o_value !== '0 || o_dr !== 4'd0) begin
            fails++;
            $display("FAIL reset_in_done: valid=%0b busy=%0b ready=%0b value=%h dr=%0d, want 0 0 1 0 0",
                     o_valid, o_busy, o_req_ready, o_value, o_dr);
        end
        i_req_valid = 1'b1; i_op = 2'd1; i_a = 32'd50; i_b = 32'd5; i_ready = 1'b1;
        tick();
        i_req_valid = 1'b0;
        repeat (5) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            seen |= o_valid | o_busy;
            tick();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_run: valid/busy seen=%0b want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v, a, b, e; logic [3:0] d, dr; logic [1:0] op; int lat; logic ar, rdy;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            dr  = 4'($urandom);
            rdy = 1'($urandom);
            e   = model(op, a, b);
            do_op(op, a, b, dr, rdy, v, d, lat, ar);
            tests++;
            if (ar !== 1'b1 || v !== e || d !== dr || lat !== model_lat(op)) begin
                fails++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: ready=%0b value=%h dr=%0d lat=%0d, want 1 %h %0d %0d",
                         n, op, a, b, ar, v, d, lat, e, dr, model_lat(op));
            end
            if (!rdy) begin
                repeat ($urandom_range(0, 3)) tick();
                i_ready = 1'b1;
            end
            tick();
            tests++;
            if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
                fails++;
                $display("FAIL random_%0d_release: valid=%0b busy=%0b, want 0 0", n, o_valid, o_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_directed();
        test_hold();
        test_flush();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
